// File: rtl/seg_display_arbiter.sv
// Shares a 4-digit 7-seg display between a background value and a timed one-shot message,
// with a blank gap after each message. Optional message blinking: define SEG_ARB_BLINK_EN.
module seg_display_arbiter #(
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned HOLD_TICKS = 1000,
    parameter bit          BLANK_LZ   = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_bg_data,
    input  logic [3:0]  i_bg_dp,
    input  logic        i_msg_valid,
    input  logic [15:0] i_msg_data,
    input  logic [3:0]  i_msg_dp,
    input  logic        i_msg_cancel,
    output logic        o_msg_ack,
    output logic        o_msg_busy,
    output logic [15:0] o_data,
    output logic [3:0]  o_dp,
    output logic [3:0]  o_turn_off,
    output logic        o_src
);

    localparam int unsigned PresW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned HoldW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [PresW-1:0] PresMax = PresW'(TICK_DIV - 1);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_TICKS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShow,
        StBlank
    } state_e;

    state_e           state_q, state_d;
    logic [PresW-1:0] presc_q, presc_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [15:0]      msg_data_q, msg_data_d;
    logic [3:0]       msg_dp_q, msg_dp_d;

    logic             tick;
    logic             hold_done;
    logic             capture;
    logic             enter_blank;
    logic             dark;
    logic [3:0]       lz_off;

    logic [15:0]      data_d;
    logic [3:0]       dp_d;
    logic [3:0]       off_d;
    logic             src_d;
    logic             busy_d;

`ifdef SEG_ARB_BLINK_EN
    logic             phase_q, phase_d;
`endif

    assign tick      = (presc_q == PresMax);
    assign hold_done = (hold_q == HoldMax);

    // Next-state: cancel beats valid only while a message is on screen.
    always_comb begin
        state_d     = state_q;
        presc_d     = tick ? '0 : presc_q + PresW'(1);
        hold_d      = hold_q;
        msg_data_d  = msg_data_q;
        msg_dp_d    = msg_dp_q;
        capture     = 1'b0;
        enter_blank = 1'b0;

        case (state_q)
            StIdle: begin
                if (i_msg_valid) begin
                    capture = 1'b1;
                end
            end
            StShow: begin
                if (i_msg_cancel) begin
                    enter_blank = 1'b1;
                end else if (i_msg_valid) begin
                    capture = 1'b1;
                end else if (tick) begin
                    if (hold_done) begin
                        enter_blank = 1'b1;
                    end else begin
                        hold_d = hold_q + HoldW'(1);
                    end
                end
            end
            StBlank: begin
                if (i_msg_valid) begin
                    capture = 1'b1;
                end else if (tick) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (capture) begin
            state_d    = StShow;
            presc_d    = '0;
            hold_d     = '0;
            msg_data_d = i_msg_data;
            msg_dp_d   = i_msg_dp;
        end

        if (enter_blank) begin
            state_d = StBlank;
            presc_d = '0;
        end
    end

`ifdef SEG_ARB_BLINK_EN
    always_comb begin
        phase_d = phase_q;
        if (capture) begin
            phase_d = 1'b0;
        end else if (state_q == StShow && tick) begin
            phase_d = ~phase_q;
        end
    end
`endif

    // A digit stays dark while it and everything above it is zero with no dp; digit0 always lit.
    always_comb begin
        lz_off = 4'h0;
        dark   = BLANK_LZ;
        for (int i = 3; i >= 1; i--) begin
            dark      = dark && (i_bg_data[4*i +: 4] == 4'h0) && !i_bg_dp[i];
            lz_off[i] = dark;
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_comb begin
        data_d = i_bg_data;
        dp_d   = i_bg_dp;
        off_d  = lz_off;
        src_d  = 1'b0;
        busy_d = (state_d != StIdle);

        case (state_d)
            StIdle: begin
                data_d = i_bg_data;
                dp_d   = i_bg_dp;
                off_d  = lz_off;
                src_d  = 1'b0;
            end
            StShow: begin
                data_d = msg_data_d;
                dp_d   = msg_dp_d;
`ifdef SEG_ARB_BLINK_EN
                off_d  = phase_d ? 4'hF : 4'h0;
`else
                off_d  = 4'h0;
`endif
                src_d  = 1'b1;
            end
            StBlank: begin
                data_d = msg_data_d;
                dp_d   = msg_dp_d;
                off_d  = 4'hF;
                src_d  = 1'b0;
            end
            default: begin
                off_d  = 4'hF;
                src_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= StIdle;
            presc_q    <= '0;
            hold_q     <= '0;
            msg_data_q <= '0;
            msg_dp_q   <= '0;
`ifdef SEG_ARB_BLINK_EN
            phase_q    <= 1'b0;
`endif
            o_msg_ack  <= 1'b0;
            o_msg_busy <= 1'b0;
            o_data     <= '0;
            o_dp       <= '0;
            o_turn_off <= 4'hF;
            o_src      <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            hold_q     <= hold_d;
            msg_data_q <= msg_data_d;
            msg_dp_q   <= msg_dp_d;
`ifdef SEG_ARB_BLINK_EN
            phase_q    <= phase_d;
`endif
            o_msg_ack  <= capture;
            o_msg_busy <= busy_d;
            o_data     <= data_d;
            o_dp       <= dp_d;
            o_turn_off <= off_d;
            o_src      <= src_d;
        end
    end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Self-checking bench for seg_display_arbiter: directed tables, corner sequences, random vs model.
module tb_seg_display_arbiter;

    localparam int unsigned TD = 4;
    localparam int unsigned HT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bg_data;
    logic [3:0]  bg_dp;
    logic        valid;
    logic [15:0] msg_data;
    logic [3:0]  msg_dp;
    logic        cancel;
    logic        ack;
    logic        busy;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  off;
    logic        src;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seg_display_arbiter #(
        .TICK_DIV  (TD),
        .HOLD_TICKS(HT),
        .BLANK_LZ  (1'b1)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_bg_data   (bg_data),
        .i_bg_dp     (bg_dp),
        .i_msg_valid (valid),
        .i_msg_data  (msg_data),
        .i_msg_dp    (msg_dp),
        .i_msg_cancel(cancel),
        .o_msg_ack   (ack),
        .o_msg_busy  (busy),
        .o_data      (data),
        .o_dp        (dp),
        .o_turn_off  (off),
        .o_src       (src)
    );

    typedef struct {
        logic [15:0] bg;
        logic [3:0]  bdp;
        logic [3:0]  exp_off;
    } lz_vec_t;

    lz_vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [15:0] d, input logic [3:0] p, input logic c);
        valid    = 1'b1;
        cancel   = c;
        msg_data = d;
        msg_dp   = p;
        step();
        valid    = 1'b0;
        cancel   = 1'b0;
    endtask

    // Counts consecutive cycles with o_src high, ending on the first cycle it is low.
    task automatic count_show(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!src) break;
            n++;
            step();
        end
    endtask

    task automatic count_blank(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy || src) break;
            n++;
            step();
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            step();
        end
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    // Leading-zero reference: everything above the highest significant digit is dark.
    function automatic logic [3:0] lz_ref(input logic [15:0] d, input logic [3:0] p);
        int top = 0;
        logic [3:0] r = 4'h0;
        for (int i = 3; i >= 1; i--) begin
            if (d[4*i +: 4] != 4'h0 || p[i]) begin
                top = i;
                break;
            end
        end
        for (int i = 1; i < 4; i++) begin
            if (i > top) r[i] = 1'b1;
        end
        return r;
    endfunction

    // Behavioural model: mode 0 idle, 1 showing, 2 blank gap; m_rem counts cycles left in mode.
    int          m_mode = 0;
    int          m_rem  = 0;
    logic [15:0] m_msg  = '0;
    logic [3:0]  m_mdp  = '0;
    logic        m_ack  = 1'b0;
    logic        m_rst  = 1'b0;

    task automatic model_step();
        logic cap = 1'b0;
        m_ack = 1'b0;
        m_rst = rst;
        if (rst) begin
            m_mode = 0;
            m_rem  = 0;
        end else begin
            case (m_mode)
                0: cap = valid;
                1: begin
                    if (cancel) begin
                        m_mode = 2;
                        m_rem  = int'(TD);
                    end else if (valid) begin
                        cap = 1'b1;
                    end else begin
                        m_rem--;
                        if (m_rem == 0) begin
                            m_mode = 2;
                            m_rem  = int'(TD);
                        end
                    end
                end
                default: begin
                    if (valid) begin
                        cap = 1'b1;
                    end else begin
                        m_rem--;
                        if (m_rem == 0) m_mode = 0;
                    end
                end
            endcase
            if (cap) begin
                m_mode = 1;
                m_rem  = int'(TD * HT);
                m_msg  = msg_data;
                m_mdp  = msg_dp;
                m_ack  = 1'b1;
            end
        end
    endtask

    task automatic model_check();
        logic [3:0]  e_off;
        logic [15:0] e_data;
        logic [3:0]  e_dp;
        logic [15:0] a_data;
        logic [3:0]  a_dp;
        logic [31:0] e_vec;
        logic [31:0] a_vec;
        a_data = data;
        a_dp   = dp;
        if (m_rst) begin
            e_off  = 4'hF;
            e_data = '0;
            e_dp   = '0;
        end else if (m_mode == 0) begin
            e_off  = lz_ref(bg_data, bg_dp);
            e_data = bg_data;
            e_dp   = bg_dp;
        end else if (m_mode == 1) begin
`ifdef SEG_ARB_BLINK_EN
            e_off  = (((int'(TD * HT) - m_rem) / int'(TD)) % 2 == 1) ? 4'hF : 4'h0;
`else
            e_off  = 4'h0;
`endif
            e_data = m_msg;
            e_dp   = m_mdp;
        end else begin
            e_off  = 4'hF;
            e_data = '0;
            e_dp   = '0;
            a_data = '0;
            a_dp   = '0;
        end
        e_vec = {5'd0, m_ack, (!m_rst && m_mode != 0), (!m_rst && m_mode == 1), e_off, e_dp, e_data};
        a_vec = {5'd0, ack, busy, src, off, a_dp, a_data};
        chk("random", a_vec, e_vec);
    endtask

    initial begin
        int n;
        logic [15:0] r16;

        vecs[0]  = '{16'h0000, 4'h0, 4'b1110};
        vecs[1]  = '{16'h0042, 4'h0, 4'b1100};
        vecs[2]  = '{16'h1234, 4'h0, 4'b0000};
        vecs[3]  = '{16'h0001, 4'h0, 4'b1110};
        vecs[4]  = '{16'h0000, 4'b0100, 4'b1000};
        vecs[5]  = '{16'h00F0, 4'h0, 4'b1100};
        vecs[6]  = '{16'h0000, 4'b1000, 4'b0000};
        vecs[7]  = '{16'h0100, 4'h0, 4'b1000};
        vecs[8]  = '{16'h000A, 4'h0, 4'b1110};
        vecs[9]  = '{16'h0000, 4'b0001, 4'b1110};
        vecs[10] = '{16'h0000, 4'b0010, 4'b1100};

        rst      = 1'b1;
        bg_data  = 16'h0042;
        bg_dp    = 4'h0;
        valid    = 1'b0;
        cancel   = 1'b0;
        msg_data = '0;
        msg_dp   = '0;
        repeat (3) step();
        chk("rst_outputs", {ack, busy, src, off, dp, data}, {1'b0, 1'b0, 1'b0, 4'hF, 4'h0, 16'h0});

        rst = 1'b0;
        step();
        chk("bg_first", {src, off, data}, {1'b0, 4'b1100, 16'h0042});

        for (int i = 0; i < 11; i++) begin
            bg_data = vecs[i].bg;
            bg_dp   = vecs[i].bdp;
            step();
            chk("lz_table", {busy, src, off, dp, data},
                {1'b0, 1'b0, vecs[i].exp_off, vecs[i].bdp, vecs[i].bg});
        end
        bg_data = 16'h0042;
        bg_dp   = 4'h0;
        step();

        // Basic message: 12 cycles shown, 4 blank, then background.
        capture(16'hBEEF, 4'b0100, 1'b0);
        chk("msg_first", {ack, busy, src, off, dp, data}, {1'b1, 1'b1, 1'b1, 4'h0, 4'b0100, 16'hBEEF});
        for (int c = 2; c <= 12; c++) begin
            step();
            chk("msg_hold", {ack, src, off, data}, {1'b0, 1'b1, 4'h0, 16'hBEEF});
        end
        for (int c = 0; c < 4; c++) begin
            step();
            chk("msg_blank", {ack, busy, src, off}, {1'b0, 1'b1, 1'b0, 4'hF});
        end
        step();
        chk("msg_back_bg", {busy, src, off, data}, {1'b0, 1'b0, 4'b1100, 16'h0042});

        // Re-capture mid-show restarts the hold.
        capture(16'h1111, 4'h0, 1'b0);
        repeat (5) step();
        capture(16'h1234, 4'h0, 1'b0);
        chk("recap_ack", {ack, src, data}, {1'b1, 1'b1, 16'h1234});
        count_show(n);
        chk("recap_len", 32'(n), 32'd12);
        wait_idle();

        // Valid and cancel together while showing: cancel wins.
        capture(16'h2222, 4'h0, 1'b0);
        repeat (2) step();
        capture(16'h3333, 4'h0, 1'b1);
        chk("vc_show", {ack, busy, src, off}, {1'b0, 1'b1, 1'b0, 4'hF});
        count_blank(n);
        chk("vc_blank_len", 32'(n), 32'd4);
        chk("vc_back_bg", {busy, src, off, data}, {1'b0, 1'b0, 4'b1100, 16'h0042});

        // Valid on the hold-expiry cycle wins.
        capture(16'h4444, 4'h0, 1'b0);
        repeat (11) step();
        capture(16'h5555, 4'h0, 1'b0);
        chk("expiry_valid", {ack, src, data}, {1'b1, 1'b1, 16'h5555});
        count_show(n);
        chk("expiry_len", 32'(n), 32'd12);

        // Valid+cancel during blank gap: capture.
        capture(16'h7777, 4'h0, 1'b1);
        chk("vc_blank", {ack, busy, src, data}, {1'b1, 1'b1, 1'b1, 16'h7777});
        wait_idle();

        // Valid+cancel in idle: capture, then reset mid-show.
        capture(16'h8888, 4'h0, 1'b1);
        chk("vc_idle", {ack, src, data}, {1'b1, 1'b1, 16'h8888});
        repeat (4) step();
        rst = 1'b1;
        step();
        chk("mid_rst", {ack, busy, src, off, dp, data}, {1'b0, 1'b0, 1'b0, 4'hF, 4'h0, 16'h0});
        rst = 1'b0;
        step();
        chk("after_rst", {busy, src, off, data}, {1'b0, 1'b0, 4'b1100, 16'h0042});

`ifdef SEG_ARB_BLINK_EN
        capture(16'hBEEF, 4'b0100, 1'b0);
        chk("blink_c1", {src, off}, {1'b1, 4'h0});
        for (int c = 2; c <= 12; c++) begin
            step();
            chk("blink", {src, off}, {1'b1, (((c - 1) / 4) % 2 == 1) ? 4'hF : 4'h0});
        end
        step();
        chk("blink_blank", {src, off}, {1'b0, 4'hF});
        wait_idle();
`endif

        // Random traffic against the model.
        rst = 1'b1;
        step();
        model_step();
        rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            r16      = 16'($urandom);
            bg_data  = r16 >> (4 * $urandom_range(0, 4));
            bg_dp    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            valid    = ($urandom_range(0, 15) == 0);
            cancel   = ($urandom_range(0, 9) == 0);
            rst      = ($urandom_range(0, 299) == 0);
            msg_data = 16'($urandom);
            msg_dp   = 4'($urandom);
            step();
            model_step();
            model_check();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
